// File: rtl/mul_share_arbiter_if.sv
// Requester, response and multiplier-side signals of the shared-multiplier arbiter.
// slave: arbiter view; master: requesters plus multiplier view.
interface mul_share_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_result;
  logic              mul_done;
  logic              mul_busy;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  mul_result, mul_done, mul_busy,
    output req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy, grant_id
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output mul_result, mul_done, mul_busy,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy, grant_id
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters,
// with a WAIT-state timeout that returns an error response.
module mul_share_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  mul_share_arbiter_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e            r_state, w_state_nxt;
  logic              r_rr_ptr, w_rr_ptr_nxt;
  logic              r_grant_id, w_grant_id_nxt;
  logic [DATA_W-1:0] r_mul_a, w_mul_a_nxt;
  logic [DATA_W-1:0] r_mul_b, w_mul_b_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [7:0]        w_cnt_inc;
  logic              w_any;
  logic              w_win;
  logic              w_accept;

  // Tie goes to rr_ptr; otherwise the single valid requester wins.
  always_comb begin
    w_any    = |io_bus.req_valid;
    w_win    = (&io_bus.req_valid) ? r_rr_ptr : io_bus.req_valid[1];
    w_accept = (r_state == StIdle) && w_any && !io_bus.mul_busy;
  end

  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rr_ptr   <= 1'b0;
      r_grant_id <= 1'b0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_mul_a    <= w_mul_a_nxt;
      r_mul_b    <= w_mul_b_nxt;
      r_rsp_data <= w_rsp_data_nxt;
      r_rsp_err  <= w_rsp_err_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    w_mul_a_nxt    = r_mul_a;
    w_mul_b_nxt    = r_mul_b;
    w_rsp_data_nxt = r_rsp_data;
    w_rsp_err_nxt  = r_rsp_err;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_grant_id_nxt = w_win;
          w_mul_a_nxt    = w_win ? io_bus.req_a1 : io_bus.req_a0;
          w_mul_b_nxt    = w_win ? io_bus.req_b1 : io_bus.req_b0;
          w_state_nxt    = StIssue;
        end
      end
      StIssue: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = StWait;
      end
      StWait: begin
        // A completion in the timeout cycle still wins over the abort.
        if (io_bus.mul_done) begin
          w_rsp_data_nxt = io_bus.mul_result;
          w_rsp_err_nxt  = 1'b0;
          w_state_nxt    = StResp;
        end else if (w_cnt_inc == TimeoutCnt) begin
          w_rsp_data_nxt = '0;
          w_rsp_err_nxt  = 1'b1;
          w_state_nxt    = StResp;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      StResp: begin
        if (io_bus.rsp_ready[r_grant_id]) begin
          w_rr_ptr_nxt = ~r_grant_id;
          w_state_nxt  = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign io_bus.req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign io_bus.rsp_valid = (r_state == StResp) ? {r_grant_id, ~r_grant_id} : 2'b00;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.mul_start = (r_state == StIssue);
  assign io_bus.mul_a     = r_mul_a;
  assign io_bus.mul_b     = r_mul_b;
  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural sequential multiplier model.
module tb_mul_share_arbiter;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.DATA_W(DW)) bus ();

  mul_share_arbiter #(.DATA_W(DW), .TIMEOUT(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int n_starts = 0;
  int lat = 32;
  logic model_en = 1'b1;
  logic force_busy = 1'b0;

  logic          m_busy;
  logic          m_done;
  int            m_cnt;
  logic [DW-1:0] m_prod;

  // Multiplier model: busy for lat cycles after mul_start, then one done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.mul_start) begin
        m_busy <= 1'b1;
        m_cnt  <= lat;
        m_prod <= bus.mul_a * bus.mul_b;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= model_en;
        end
      end
    end
  end

  assign bus.mul_busy   = m_busy | force_busy;
  assign bus.mul_done   = m_done;
  assign bus.mul_result = m_prod;

  always @(posedge clk) if (bus.mul_start) n_starts <= n_starts + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One full operation: accept, issue, wait, optional stall, response handshake.
  task automatic do_op(input logic g, input logic [31:0] data, input logic err,
                       input int hold, input int exp_cycles, input string tag);
    int n;
    int s0;
    logic prev_done;
    logic [1:0] onehot;
    logic [DW-1:0] sa0, sb0, sa1, sb1;
    onehot = g ? 2'b10 : 2'b01;
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(onehot));
    s0 = n_starts;
    tick();
    chk({tag, ".mul_start"}, 64'(bus.mul_start), 64'd1);
    chk({tag, ".grant_id"}, 64'(bus.grant_id), 64'(g));
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    // Operands scrambled while in flight must not reach the result.
    sa0 = bus.req_a0; sb0 = bus.req_b0; sa1 = bus.req_a1; sb1 = bus.req_b1;
    bus.req_a0 = $urandom; bus.req_b0 = $urandom;
    bus.req_a1 = $urandom; bus.req_b1 = $urandom;
    n = 0;
    prev_done = 1'b0;
    while (bus.rsp_valid == 2'b00 && n < 200) begin
      prev_done = bus.mul_done;
      tick();
      n++;
    end
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(onehot));
    chk({tag, ".rsp_data"}, 64'(bus.rsp_data), 64'(data));
    chk({tag, ".rsp_err"}, 64'(bus.rsp_err), 64'(err));
    chk({tag, ".done_then_valid"}, 64'(prev_done), 64'(!err));
    chk({tag, ".starts"}, 64'(n_starts - s0), 64'd1);
    if (exp_cycles > 0) chk({tag, ".cycles"}, 64'(n), 64'(exp_cycles));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_valid"}, 64'(bus.rsp_valid), 64'(onehot));
      chk({tag, ".hold_data"}, 64'(bus.rsp_data), 64'(data));
      chk({tag, ".hold_req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = onehot;
    #1;
    chk({tag, ".hs_req_ready"}, 64'(bus.req_ready), 64'd0);
    tick();
    bus.rsp_ready = 2'b00;
    bus.req_a0 = sa0; bus.req_b0 = sb0; bus.req_a1 = sa1; bus.req_b1 = sb1;
    chk({tag, ".post_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".post_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    bus.rsp_ready = 2'b00;

    // Reset state
    repeat (2) tick();
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst.rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst.rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst.mul_start", 64'(bus.mul_start), 64'd0);
    chk("rst.mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst.mul_b", 64'(bus.mul_b), 64'd0);
    chk("rst.grant_id", 64'(bus.grant_id), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single requester 0: 6*7
    bus.req_valid = 2'b01; bus.req_a0 = 32'd6; bus.req_b0 = 32'd7;
    do_op(1'b0, 32'd42, 1'b0, 0, -1, "t1");
    bus.req_valid = 2'b00;

    // Both valid after reset: strict alternation, third op stalled on rsp_ready
    reset_dut();
    bus.req_a0 = 32'd3; bus.req_b0 = 32'd5; bus.req_a1 = 32'd4; bus.req_b1 = 32'd4;
    bus.req_valid = 2'b11;
    do_op(1'b0, 32'd15, 1'b0, 0, -1, "t2a");
    do_op(1'b1, 32'd16, 1'b0, 0, -1, "t2b");
    do_op(1'b0, 32'd15, 1'b0, 10, -1, "t2c");
    do_op(1'b1, 32'd16, 1'b0, 0, -1, "t2d");
    bus.req_valid = 2'b00;

    // Timeout: no done ever; 1 ISSUE + 64 WAIT cycles before RESP
    model_en = 1'b0;
    bus.req_valid = 2'b10; bus.req_a1 = 32'd9; bus.req_b1 = 32'd9;
    do_op(1'b1, 32'd0, 1'b1, 0, 65, "t3");
    bus.req_valid = 2'b00;
    model_en = 1'b1;

    // Reset mid-WAIT
    bus.req_valid = 2'b10; bus.req_a1 = 32'd5; bus.req_b1 = 32'd5;
    #1;
    chk("t4.req_ready", 64'(bus.req_ready), 64'd2);
    tick();
    bus.req_valid = 2'b00;
    repeat (5) tick();
    chk("t4.busy_wait", 64'(bus.busy), 64'd1);
    chk("t4.mul_a_wait", 64'(bus.mul_a), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("t4.busy", 64'(bus.busy), 64'd0);
    chk("t4.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t4.mul_start", 64'(bus.mul_start), 64'd0);
    chk("t4.mul_a", 64'(bus.mul_a), 64'd0);
    chk("t4.mul_b", 64'(bus.mul_b), 64'd0);
    chk("t4.grant_id", 64'(bus.grant_id), 64'd0);
    chk("t4.rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("t4.rsp_data", 64'(bus.rsp_data), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("t4.no_residual", 64'(bus.rsp_valid), 64'd0);
    end
    bus.req_valid = 2'b01; bus.req_a0 = 32'd2; bus.req_b0 = 32'hFFFF_FFFF;
    do_op(1'b0, 32'hFFFF_FFFE, 1'b0, 0, -1, "t4");
    bus.req_valid = 2'b00;

    // mul_busy blocks acceptance in IDLE
    force_busy = 1'b1;
    bus.req_valid = 2'b01; bus.req_a0 = 32'd11; bus.req_b0 = 32'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5.req_ready_busy", 64'(bus.req_ready), 64'd0);
      chk("t5.idle", 64'(bus.busy), 64'd0);
    end
    force_busy = 1'b0;
    #1;
    chk("t5.req_ready_free", 64'(bus.req_ready), 64'd1);
    do_op(1'b0, 32'd33, 1'b0, 0, -1, "t5");
    bus.req_valid = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
